// File: rtl/regfile_wb.sv
// Register-file write-port arbiter: single-cycle ALU results take priority over
// queued load results, with write-after-write kill and a starvation guard.
module regfile_wb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic [4:0]  rd_id,
    output logic [31:0] rd_data,
    output logic [31:0] pend_mask
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [4:0]       slot_rd_reg [DEPTH];
    logic [31:0]      slot_data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg, valid_next;
    logic [DEPTH-1:0] kill_reg, kill_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [STV_W-1:0] starve_reg, starve_next;
    logic             alu_stall_reg;
    logic [4:0]       rd_id_reg;
    logic [31:0]      rd_data_reg;

    logic fifo_empty, push, pop, alu_win, push_kill;

    assign fifo_empty = (count_reg == '0);
    assign lsu_ready  = rst_n && (count_reg < CNT_W'(DEPTH));
    assign push       = lsu_valid && lsu_ready && (lsu_rd != 5'd0);
    assign alu_win    = !alu_stall_reg && alu_valid && (alu_rd != 5'd0);
    assign pop        = !alu_win && !fifo_empty;
    // A same-cycle ALU result is younger than the load being pushed.
    assign push_kill  = alu_win && (lsu_rd == alu_rd);

    assign alu_stall = alu_stall_reg;
    assign rd_id     = rd_id_reg;
    assign rd_data   = rd_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic slot_push, slot_pop, slot_hit;
            assign slot_push      = push && (wr_ptr_reg == PTR_W'(gi));
            assign slot_pop       = pop && (rd_ptr_reg == PTR_W'(gi));
            assign slot_hit       = alu_win && (slot_rd_reg[gi] == alu_rd);
            assign valid_next[gi] = slot_push | (valid_reg[gi] & ~slot_pop);
            assign kill_next[gi]  = slot_push ? push_kill : (kill_reg[gi] | slot_hit);
        end
    endgenerate

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        starve_next = starve_reg;
        if (fifo_empty || pop)
            starve_next = '0;
        else if (starve_reg < STV_W'(STARVE_LIMIT))
            starve_next = starve_reg + STV_W'(1);
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_reg[i] && !kill_reg[i])
                pend_mask[slot_rd_reg[i]] = 1'b1;
        end
        if (rd_id_reg != 5'd0)
            pend_mask[rd_id_reg] = 1'b1;
        pend_mask[0] = 1'b0;
    end

    // Payload storage has no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push)
            slot_data_mem[wr_ptr_reg] <= lsu_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg     <= '0;
            kill_reg      <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            starve_reg    <= '0;
            alu_stall_reg <= 1'b0;
            rd_id_reg     <= 5'd0;
            rd_data_reg   <= 32'd0;
            for (int i = 0; i < DEPTH; i++)
                slot_rd_reg[i] <= 5'd0;
        end else begin
            valid_reg     <= valid_next;
            kill_reg      <= kill_next;
            count_reg     <= count_next;
            starve_reg    <= starve_next;
            alu_stall_reg <= (starve_next == STV_W'(STARVE_LIMIT));
            if (push) begin
                slot_rd_reg[wr_ptr_reg] <= lsu_rd;
                wr_ptr_reg              <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (alu_win) begin
                rd_id_reg   <= alu_rd;
                rd_data_reg <= alu_data;
            end else if (pop) begin
                rd_id_reg   <= kill_reg[rd_ptr_reg] ? 5'd0 : slot_rd_reg[rd_ptr_reg];
                rd_data_reg <= slot_data_mem[rd_ptr_reg];
            end else begin
                rd_id_reg <= 5'd0;
            end
        end
    end
endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
Write-side driver for the 32-entry register file. It merges single-cycle ALU results and variable-latency load results onto the single write port (rd_id/rd_data, where rd_id = 0 means no write). Load results wait in a small FIFO, and a starvation guard holds off the ALU when loads wait too long. It enforces write-after-write order and exports a pending-write mask to the hazard logic.

Parameters:
DEPTH, 2, number of load-result FIFO entries (power of two, at least 2).
STARVE_LIMIT, 4, consecutive cycles the FIFO head may wait before alu_stall is raised (at least 1).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  active-low asynchronous reset
alu_valid  input  1  ALU result present this cycle; cannot be back-pressured
alu_rd  input  5  ALU destination register
alu_data  input  32  ALU result
alu_stall  output  1  registered; ALU must not present a result this cycle
lsu_valid  input  1  load result offered
lsu_ready  output  1  load result accepted when lsu_valid && lsu_ready
lsu_rd  input  5  load destination register
lsu_data  input  32  load result
rd_id  output  5  registered register-file write index; 0 means no write
rd_data  output  32  registered register-file write data
pend_mask  output  32  bit r = 1 means a write to register r is queued or on the write port

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: rd_id = 0, rd_data = 0, alu_stall = 0, FIFO empty, all kill flags cleared, starvation counter = 0, pend_mask = 0.
- lsu_ready:
  - lsu_ready = rst_n && (count < DEPTH), from registered count only.
  - A pop in the same cycle does not make a full FIFO ready; there is no pass-through.
- Enqueue:
  - On lsu_valid && lsu_ready with lsu_rd != 0, push {lsu_rd, lsu_data}.
  - With lsu_rd = 0, the handshake completes and nothing is pushed.
- Write-port select, once per cycle, in priority order:
  - (1) alu_stall = 0, alu_valid = 1 and alu_rd != 0: ALU wins.
  - (2) FIFO non-empty: pop the head.
  - (3) Otherwise idle.
- Write-port outputs:
  - The winner is registered into rd_id/rd_data at the edge.
  - A killed head pops with rd_id = 0; rd_data for a killed head is don't-care.
  - When idle, rd_id = 0 and rd_data holds its previous value.
  - The register file commits on the following edge, so an input sampled at edge N is visible in the register file after edge N+1.
- WAW kill:
  - When the ALU wins with alu_rd = r, every FIFO entry with rd = r is marked killed.
  - This includes an entry being pushed in the same cycle; a same-cycle ALU result is defined as younger than a same-cycle load.
  - Killed entries occupy their slot until popped normally.
- While alu_stall = 1:
  - alu_valid is ignored. Asserting alu_valid then is an upstream protocol violation; the result is dropped and no error is flagged.
  - The head pops that cycle.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Resets to 0 on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
  - alu_stall is registered: it is 1 in the cycle after the counter reaches STARVE_LIMIT, and it clears after the pop.
- pend_mask (combinational from registered state only):
  - Set bits: rd of every non-killed FIFO entry, plus rd_id when rd_id != 0.
  - Bit 0 is always 0.
  - Duplicate register indices OR together.
- FIFO pointers wrap modulo DEPTH. count is ceil(log2(DEPTH+1)) bits, holding values 0..DEPTH.
- Asynchronous reset mid-operation discards all queued entries and clears rd_id immediately; no write reaches the register file.

Test Plan:
- Reset, then ALU-only traffic: alu_valid = 1, alu_rd = 5, alu_data = 0xDEADBEEF at edge N -> rd_id = 5, rd_data = 0xDEADBEEF after edge N; lsu_ready = 1; pend_mask = 0x20 during that cycle.
- Load path: lsu_valid, lsu_rd = 7, lsu_data = 0x1234 with ALU idle -> rd_id = 7 one edge after acceptance. alu_rd = 0 with alu_valid = 1 must not block the pop.
- Fill and back-pressure: three back-to-back loads to x1/x2/x3 while the ALU writes x10 every cycle -> lsu_ready = 0 after two accepts; the third load is held until a slot frees; no load is lost or reordered.
- Starvation: FIFO holds x9 and alu_valid stays high (STARVE_LIMIT = 4) -> alu_stall = 1 on the fifth cycle; x9 is written that cycle; alu_stall = 0 on the next cycle.
- WAW kill: queue load x4 = 0xAAAA, then ALU x4 = 0xBBBB wins -> x4 ends at 0xBBBB; the later pop shows rd_id = 0; pend_mask bit 4 clears once the ALU write leaves the port. Repeat with the load and ALU to x4 arriving in the same cycle -> same result.
- Reset mid-operation: FIFO full and rd_id = 3, assert rst_n low asynchronously -> rd_id = 0, pend_mask = 0, lsu_ready = 0 while low and 1 after release; no stale entries written afterwards.
